// File: rtl/line_job_scheduler_if.sv
// ----------------------------------------------------------------------------
// line_job_scheduler_if
// Purpose : Bundles the scheduler <-> worker-pool signals for one render line.
// Signals :
//   sphere          - active sphere the workers render with (scheduler drives)
//   pixel_y         - signed row being rendered (scheduler drives)
//   worker_activate - start strobe, held high until every worker is busy
//   worker_busy     - per-worker busy flags (worker pool drives)
//   line_commit     - one-cycle pulse: copy the line buffer to the VGA register
// Modports: master = scheduler side, slave = worker pool side.
// ----------------------------------------------------------------------------
interface line_job_scheduler_if #(
    parameter int N_WORKERS = 4,
    parameter int Y_W       = 12
);
    logic [63:0]              sphere;
    logic signed [Y_W-1:0]    pixel_y;
    logic                     worker_activate;
    logic [N_WORKERS-1:0]     worker_busy;
    logic                     line_commit;

    modport master (
        output sphere,
        output pixel_y,
        output worker_activate,
        output line_commit,
        input  worker_busy
    );

    modport slave (
        input  sphere,
        input  pixel_y,
        input  worker_activate,
        input  line_commit,
        output worker_busy
    );
endinterface

// File: rtl/line_job_scheduler.sv
// ----------------------------------------------------------------------------
// line_job_scheduler
// Purpose : Sequences one render line across the raytracing worker pool.
//           Detects VGA line requests, computes the signed pixel row, runs the
//           activate/busy handshake with every worker and issues a one-cycle
//           commit strobe. Owns the active sphere register; scene words from
//           SPI are parked in a shadow copy and applied only between lines.
// Ports   :
//   CLK100MHZ      - system clock
//   ck_rst_        - asynchronous active-low reset
//   next_line      - VGA line request level (already synchronous)
//   next_y         - unsigned row index accompanying next_line
//   recv_dv        - SPI scene word valid pulse
//   recv_64bit     - SPI scene word
//   recv_interrupt - high while a scene word can be accepted and applied
//   workers        - worker-pool handshake bundle (master side)
//   ack_error      - sticky flag: workers failed to acknowledge in time
//   overrun_cnt    - saturating count of dropped/merged line requests
//   state_dbg      - current FSM state encoding
// ----------------------------------------------------------------------------
module line_job_scheduler #(
    parameter int          N_WORKERS      = 4,
    parameter int          Y_W            = 12,
    parameter int          Y_OFFSET       = 240,
    parameter int          ACK_TIMEOUT    = 16,
    parameter logic [63:0] DEFAULT_SPHERE = 64'hFF9C_FF38_0190_0600
) (
    input  logic                          CLK100MHZ,
    input  logic                          ck_rst_,
    input  logic                          next_line,
    input  logic [Y_W-1:0]                next_y,
    input  logic                          recv_dv,
    input  logic [63:0]                   recv_64bit,
    output logic                          recv_interrupt,
    line_job_scheduler_if.master          workers,
    output logic                          ack_error,
    output logic [7:0]                    overrun_cnt,
    output logic [2:0]                    state_dbg
);

    localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        LAUNCH   = 3'd2,
        WAIT_ACK = 3'd3,
        RENDER   = 3'd4,
        COMMIT   = 3'd5
    } state_t;

    state_t                state;
    state_t                next_state;

    logic                  line_prev;
    logic                  line_req;
    logic                  req_pending;
    logic [Y_W-1:0]        y_lat;
    logic [63:0]           shadow;
    logic [63:0]           sphere_q;
    logic signed [Y_W-1:0] pixel_y_q;
    logic [ACK_W-1:0]      ack_cnt;
    logic                  all_busy;
    logic                  none_busy;
    logic                  ack_expired;

    assign line_req    = next_line && !line_prev;
    assign all_busy    = (workers.worker_busy == {N_WORKERS{1'b1}});
    assign none_busy   = (workers.worker_busy == {N_WORKERS{1'b0}});
    assign ack_expired = (ack_cnt == ACK_W'(ACK_TIMEOUT - 1));

    // State register.
    always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
        if (!ck_rst_) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. An acknowledge that arrives on the final counted
    // cycle still wins over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (req_pending) next_state = SETUP;
            SETUP:    next_state = LAUNCH;
            LAUNCH:   if (none_busy) next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (all_busy) begin
                    next_state = RENDER;
                end else if (ack_expired) begin
                    next_state = IDLE;
                end
            end
            RENDER:   if (none_busy) next_state = COMMIT;
            COMMIT:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Outputs. worker_activate is high for exactly the WAIT_ACK residency,
    // which is what a registered set-on-entry / clear-on-exit strobe gives.
    always_comb begin
        workers.worker_activate = (state == WAIT_ACK);
        workers.line_commit     = (state == COMMIT);
        workers.sphere          = sphere_q;
        workers.pixel_y         = pixel_y_q;
        state_dbg               = state;
    end

    // Datapath: request capture, scene shadowing, row computation, ack
    // timer and status. A new request always re-arms req_pending, so a
    // request that lands while busy is merged into the next line with the
    // newest row index rather than lost.
    always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
        if (!ck_rst_) begin
            line_prev      <= 1'b0;
            req_pending    <= 1'b0;
            y_lat          <= '0;
            shadow         <= DEFAULT_SPHERE;
            sphere_q       <= DEFAULT_SPHERE;
            pixel_y_q      <= '0;
            ack_cnt        <= '0;
            recv_interrupt <= 1'b0;
            ack_error      <= 1'b0;
            overrun_cnt    <= 8'd0;
        end else begin
            line_prev <= next_line;

            if (recv_dv) begin
                shadow <= recv_64bit;
            end

            if (line_req) begin
                y_lat       <= next_y;
                req_pending <= 1'b1;
                if ((req_pending || state != IDLE) && overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end else if (state == IDLE && req_pending) begin
                req_pending <= 1'b0;
            end

            if (state == IDLE && !req_pending && !recv_dv) begin
                sphere_q       <= shadow;
                recv_interrupt <= 1'b1;
            end else if (state == IDLE && req_pending) begin
                recv_interrupt <= 1'b0;
            end

            if (state == SETUP) begin
                pixel_y_q <= $signed(y_lat - Y_W'(Y_OFFSET));
            end

            if (state == LAUNCH) begin
                ack_cnt <= '0;
            end else if (state == WAIT_ACK) begin
                ack_cnt <= ack_cnt + 1'b1;
            end

            if (state == WAIT_ACK && !all_busy && ack_expired) begin
                ack_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/line_job_scheduler.md
Name: line_job_scheduler

Overview:
- Sequences one render line across the raytracing worker pool.
- Detects line requests from the VGA block and computes the signed pixel row.
- Runs the activate/busy handshake with all workers, then issues a one-cycle commit strobe so the finished line buffer is copied to the VGA line register.
- Owns the active sphere register. New scene words from SPI are applied only between lines, so a line is never rendered with a half-changed scene.

Parameters:
- N_WORKERS, 4, number of worker instances; width of worker_busy.
- Y_W, 12, width of next_y and pixel_y.
- Y_OFFSET, 240, subtracted from next_y to centre the row.
- ACK_TIMEOUT, 16, cycles allowed for all workers to report busy after activate.
- DEFAULT_SPHERE, 64-bit, reset value of the sphere register (x=-100, y=-200, z=400, r=6, colour 0 in the Types::Sphere packing).

Ports:
- CLK100MHZ, input, 1, system clock.
- ck_rst_, input, 1, asynchronous active-low reset.
- next_line, input, 1, VGA line request level, already synchronous to CLK100MHZ.
- next_y, input, Y_W, unsigned row index that accompanies next_line.
- recv_dv, input, 1, SPI scene word valid (single-cycle pulse).
- recv_64bit, input, 64, SPI scene word.
- recv_interrupt, output, 1, high when the scheduler can accept and apply a scene word.
- sphere, output, 64, active sphere delivered to the workers.
- pixel_y, output, Y_W signed, row currently being rendered.
- worker_activate, output, 1, start strobe held high until acknowledged.
- worker_busy, input, N_WORKERS, per-worker busy flags.
- line_commit, output, 1, one-cycle pulse telling the top level to copy the line buffer.
- ack_error, output, 1, sticky flag for a worker acknowledge timeout.
- overrun_cnt, output, 8, saturating count of line requests dropped or merged.
- state_dbg, output, 3, current state encoding.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-line):
  - state=IDLE; sphere=DEFAULT_SPHERE; shadow=DEFAULT_SPHERE; pixel_y=0.
  - worker_activate=0, line_commit=0, recv_interrupt=0, ack_error=0, overrun_cnt=0, req_pending=0.
- Request detect:
  - next_line is registered; a rising edge (prev=0, now=1) is a request.
  - On a request, next_y is latched into y_lat and req_pending is set.
  - If req_pending is already set, or state is not IDLE, when the edge arrives: overrun_cnt increments, saturating at 255, and y_lat is overwritten with the newest next_y.
- Scene path:
  - recv_dv=1 latches recv_64bit into shadow in any state.
  - In IDLE with req_pending=0 and recv_dv=0: sphere<=shadow and recv_interrupt<=1.
  - recv_interrupt clears to 0 on the cycle SETUP is entered.
- States:
  - IDLE(0): if req_pending, go to SETUP and clear req_pending in the same cycle.
  - SETUP(1): pixel_y <= y_lat - Y_OFFSET, using Y_W-bit two's-complement wrap. Then go to LAUNCH.
  - LAUNCH(2): stay while worker_busy != 0. When worker_busy == 0, set worker_activate<=1, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK(3): hold worker_activate=1 and count cycles.
    - If worker_busy is all ones: worker_activate<=0, go to RENDER.
    - If the count reaches ACK_TIMEOUT first: worker_activate<=0, ack_error<=1, go to IDLE with no commit.
  - RENDER(4): when worker_busy == 0, go to COMMIT.
  - COMMIT(5): line_commit=1 for exactly this cycle, then go to IDLE.
- Latencies:
  - Request edge to SETUP: 2 cycles (registered edge detect, then IDLE decision).
  - Workers idle to line_commit: SETUP(1) + LAUNCH(1) + ack cycles + render cycles + 1.
- sphere and pixel_y are stable from SETUP through COMMIT. Neither changes while worker_activate or any worker_busy bit is high.
- Simultaneous recv_dv and request edge in IDLE: shadow updates, sphere is not applied, the line renders with the old sphere, and the new sphere is applied in the next eligible IDLE cycle.
- ack_error clears only on reset.
- Unused state encodings 6 and 7 go to IDLE.

Test Plan:
- Reset, idle 3 cycles -> sphere=DEFAULT_SPHERE, recv_interrupt=1, all strobes 0, state_dbg=0.
- next_y=100, rising next_line; worker model goes busy 1 cycle after activate and clears after 20 cycles -> pixel_y=-140, worker_activate high until all busy, exactly one line_commit pulse, back to IDLE.
- next_y=0, then next_y=479 -> pixel_y=-240 and pixel_y=239 respectively; no truncation or sign error.
- recv_dv with 64'h0123_4567_89AB_CDEF during RENDER -> sphere unchanged until IDLE, then equals that word; recv_interrupt low from SETUP to COMMIT.
- Second next_line edge during RENDER with next_y=7 -> overrun_cnt=1; next line renders with pixel_y=-233.
- Workers never assert busy -> ack_error=1 after 16 cycles in WAIT_ACK, no line_commit. Then assert ck_rst_=0 mid-WAIT_ACK -> immediately state_dbg=0, worker_activate=0, ack_error=0.
